// File: rtl/char_vram_arbiter.sv
// Single-port text RAM arbiter: VGA fetch > clear/scroll engine > CPU, one RAM access per cycle.
// Define VRAM_CURSOR_EN to add the blinking underscore cursor overlay on the VGA read path.
module char_vram_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int AW = 13,
  parameter int DW = 7,
  parameter logic [DW-1:0] BLANK = 7'h20
`ifdef VRAM_CURSOR_EN
  ,
  parameter int BLINK_BITS = 24
`endif
) (
  input  logic          sys_clk,
  input  logic          clrn,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_valid,
  output logic [DW-1:0] vga_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          cmd_clear,
  input  logic          cmd_scroll,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef VRAM_CURSOR_EN
  ,
  input  logic [AW-1:0] cursor_addr,
  input  logic          cursor_on
`endif
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [AW-1:0] CELLS_A = AW'(CELLS);
  localparam logic [AW-1:0] LAST_A = AW'(CELLS - 1);
  localparam logic [AW-1:0] SC_LAST_A = AW'(CELLS - COLS - 1);
  localparam logic [AW-1:0] COLS_A = AW'(COLS);
  localparam logic [DW-1:0] CURSOR_CHAR = 7'h5F;

  typedef enum logic [2:0] {IDLE, CLEAR, SC_RD, SC_WR, SC_FILL} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          rd_pend_q, rd_pend_d;
  logic          busy_q, busy_d;
  logic          vga_valid_q, vga_valid_d;
  logic          vga_oob_q, vga_oob_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          cpu_rd_q, cpu_rd_d;
  logic          cpu_oob_q, cpu_oob_d;
  logic          cpu_lock_q, cpu_lock_d;
  logic          cur_hit_q;

  logic          eng_gnt, cpu_gnt, vga_oob, cpu_oob;
  logic [AW-1:0] eng_addr;
  logic          eng_we;
  logic [DW-1:0] eng_wdata;

  always_comb begin
    vga_oob = (vga_addr >= CELLS_A);
    cpu_oob = (cpu_addr >= CELLS_A);
    eng_gnt = (state_q != IDLE) && !vga_req;
    cpu_gnt = cpu_req && !cpu_lock_q && !vga_req && (state_q == IDLE);

    eng_addr  = ptr_q;
    eng_we    = 1'b1;
    eng_wdata = BLANK;
    case (state_q)
      SC_RD: begin
        eng_addr = ptr_q + COLS_A;
        eng_we   = 1'b0;
      end
      // Read data lands this cycle; forward it so a granted write needs no extra cycle.
      SC_WR:   eng_wdata = rd_pend_q ? ram_rdata : hold_q;
      default: ;
    endcase

    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (vga_req) begin
      ram_addr = vga_addr;
    end else if (eng_gnt) begin
      ram_addr  = eng_addr;
      ram_we    = eng_we;
      ram_wdata = eng_wdata;
    end else if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we && !cpu_oob;
      ram_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = rd_pend_q ? ram_rdata : hold_q;
    rd_pend_d = (state_q == SC_RD) && eng_gnt;
    case (state_q)
      IDLE: begin
        if (cmd_clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (cmd_scroll) begin
          state_d = SC_RD;
          ptr_d   = '0;
        end
      end
      CLEAR, SC_FILL: begin
        if (eng_gnt) begin
          if (ptr_q == LAST_A) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      SC_RD: if (eng_gnt) state_d = SC_WR;
      SC_WR: begin
        if (eng_gnt) begin
          ptr_d   = ptr_q + AW'(1);
          state_d = (ptr_q == SC_LAST_A) ? SC_FILL : SC_RD;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase

    busy_d      = (state_d != IDLE);
    vga_valid_d = vga_req;
    vga_oob_d   = vga_req && vga_oob;
    cpu_ack_d   = cpu_gnt;
    cpu_rd_d    = cpu_gnt && !cpu_we;
    cpu_oob_d   = cpu_gnt && cpu_oob;
    // A served request must be seen low once before it can be granted again.
    cpu_lock_d  = cpu_gnt || (cpu_lock_q && cpu_req);
  end

  always_ff @(posedge sys_clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_oob_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_oob_q   <= 1'b0;
      cpu_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      rd_pend_q   <= rd_pend_d;
      busy_q      <= busy_d;
      vga_valid_q <= vga_valid_d;
      vga_oob_q   <= vga_oob_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_oob_q   <= cpu_oob_d;
      cpu_lock_q  <= cpu_lock_d;
    end
  end

`ifdef VRAM_CURSOR_EN
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  cur_hit_d;

  always_comb begin
    blink_d   = blink_q + BLINK_BITS'(1);
    cur_hit_d = vga_req && cursor_on && blink_q[BLINK_BITS-1] && (vga_addr == cursor_addr);
  end

  always_ff @(posedge sys_clk or negedge clrn) begin
    if (!clrn) begin
      blink_q   <= '0;
      cur_hit_q <= 1'b0;
    end else begin
      blink_q   <= blink_d;
      cur_hit_q <= cur_hit_d;
    end
  end
`else
  assign cur_hit_q = 1'b0;
`endif

  assign busy      = busy_q;
  assign vga_valid = vga_valid_q;
  assign cpu_ack   = cpu_ack_q;

  always_comb begin
    vga_data = '0;
    if (vga_valid_q) vga_data = cur_hit_q ? CURSOR_CHAR : (vga_oob_q ? BLANK : ram_rdata);
    cpu_rdata = '0;
    if (cpu_rd_q) cpu_rdata = cpu_oob_q ? BLANK : ram_rdata;
  end

endmodule

// File: tb/tb_char_vram_arbiter.sv
// Randomized bench for char_vram_arbiter against a screen-level model of the character RAM.
module tb_char_vram_arbiter;
  localparam int COLS = 80, ROWS = 60, CELLS = COLS * ROWS, AW = 13, DW = 7;
  localparam int BLANK = 'h20;

  logic          sys_clk = 1'b0, clrn = 1'b0;
  logic          vga_req = 1'b0, vga_valid;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_data;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, cpu_rdata;
  logic          cmd_clear = 1'b0, cmd_scroll = 1'b0, busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  char_vram_arbiter dut (
    .sys_clk(sys_clk), .clrn(clrn),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll), .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous single-port RAM seen by the DUT.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_rd;
  always @(posedge sys_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    mem_rd <= mem[ram_addr];
  end
  assign ram_rdata = mem_rd;

  // Expected screen contents; -1 marks a cell never written.
  int shadow [CELLS];
  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int exp_cell(input int a);
    return (a < CELLS) ? shadow[a] : BLANK;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) shadow[i] = BLANK;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < CELLS; i++) shadow[i] = (i < CELLS - COLS) ? shadow[i + COLS] : BLANK;
  endtask

  task automatic cpu_access(input bit we, input int addr, input int wdata,
                            output int rdata, output int lat, output bit wen);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = DW'(wdata);
    #1;
    wen = ram_we;
    rdata = -1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack && lat < 20000);
    if (cpu_ack) rdata = int'(cpu_rdata);
    else check("cpu_timeout", 0, 1);
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic cpu_write(input int addr, input int d);
    int r, lat;
    bit wen;
    cpu_access(1'b1, addr, d, r, lat, wen);
    if (addr < CELLS) shadow[addr] = d;
  endtask

  task automatic vga_sweep(input int lo, input int hi, input string tag);
    for (int a = lo; a <= hi; a++) begin
      vga_req = 1'b1; vga_addr = AW'(a);
      tick();
      check(tag, int'({vga_valid, vga_data}), 128 | exp_cell(a));
    end
    vga_req = 1'b0;
  endtask

  task automatic engine_run(input bit clr, input bit scr, input int steal_pct, input int poke_at,
                            input bit cpu_during, output int nbusy, output int nsteal,
                            output bit ack_early);
    cmd_clear = clr; cmd_scroll = scr;
    tick();
    cmd_clear = 1'b0; cmd_scroll = 1'b0;
    if (cpu_during) cpu_req = 1'b1;
    nbusy = 0; nsteal = 0; ack_early = 1'b0;
    while (busy && nbusy < 30000) begin
      nbusy++;
      if (cpu_ack) ack_early = 1'b1;
      cmd_scroll = (nbusy == poke_at);
      cmd_clear  = (nbusy == poke_at + 50);
      if ($urandom_range(99) < steal_pct) begin
        vga_req = 1'b1; vga_addr = AW'($urandom_range(CELLS - 1)); nsteal++;
      end else begin
        vga_req = 1'b0;
      end
      tick();
    end
    cmd_scroll = 1'b0; cmd_clear = 1'b0; vga_req = 1'b0;
  endtask

  initial begin
    int r, lat, nb, ns;
    bit wen, early, flag;

    for (int i = 0; i < CELLS; i++) shadow[i] = -1;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_vga_valid", vga_valid, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_vga_data", vga_data, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    clrn = 1'b1;
    tick();

    // 1: CPU write then read, plus re-grant lockout
    cpu_access(1'b1, 12, 'h41, r, lat, wen);
    check("t1_wr_we", wen, 1);
    check("t1_wr_lat", lat, 1);
    shadow[12] = 'h41;
    cpu_access(1'b0, 12, 0, r, lat, wen);
    check("t1_rd_we", wen, 0);
    check("t1_rd_lat", lat, 1);
    check("t1_rd_data", r, 'h41);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12;
    tick(); check("t1_ack", cpu_ack, 1);
    tick(); check("t1_lock0", cpu_ack, 0);
    tick(); check("t1_lock1", cpu_ack, 0);
    cpu_req = 1'b0; tick();
    cpu_req = 1'b1; tick(); check("t1_regrant", cpu_ack, 1);
    cpu_req = 1'b0; tick();
    vga_sweep(12, 12, "t1_vga12");

    // 2: VGA every cycle starves CPU; CPU served right after VGA drops
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12;
    for (int k = 0; k < 8; k++) begin
      vga_req = 1'b1; vga_addr = AW'(k * 7);
      tick();
      check("t2_vga_valid", vga_valid, 1);
      check("t2_no_ack", cpu_ack, 0);
    end
    vga_req = 1'b0;
    tick();
    check("t2_ack", cpu_ack, 1);
    check("t2_rdata", cpu_rdata, 'h41);
    check("t2_vga_idle", vga_valid, 0);
    cpu_req = 1'b0; tick();

    // 3: clear screen
    engine_run(1'b1, 1'b0, 0, -1, 1'b0, nb, ns, early);
    check("t3_busy_cycles", nb, CELLS);
    model_clear();
    vga_sweep(0, CELLS - 1, "t3_vga");
    vga_sweep(CELLS, CELLS + 1, "t3_vga_oob");
    vga_sweep((1 << AW) - 1, (1 << AW) - 1, "t3_vga_top");

    // Random CPU/VGA traffic, including out-of-range addresses
    for (int k = 0; k < 300; k++) begin
      int a, d, op;
      op = $urandom_range(2);
      a = ($urandom_range(9) == 0) ? $urandom_range((1 << AW) - 1, CELLS) : $urandom_range(CELLS - 1);
      d = $urandom_range(127);
      if (op == 0) begin
        cpu_access(1'b1, a, d, r, lat, wen);
        check("rnd_we", wen, (a < CELLS) ? 1 : 0);
        check("rnd_wlat", lat, 1);
        if (a < CELLS) shadow[a] = d;
      end else if (op == 1) begin
        cpu_access(1'b0, a, 0, r, lat, wen);
        check("rnd_rd", r, exp_cell(a));
      end else begin
        vga_sweep(a, a, "rnd_vga");
      end
    end

    // 4: scroll a numbered screen, with a CPU write waiting behind the engine
    for (int i = 0; i < CELLS; i++) cpu_write(i, i % 128);
    cpu_we = 1'b1; cpu_addr = 5; cpu_wdata = 'h77;
    engine_run(1'b0, 1'b1, 0, -1, 1'b1, nb, ns, early);
    check("t4_busy_cycles", nb, 2 * (CELLS - COLS) + COLS);
    check("t4_no_ack_busy", early, 0);
    tick();
    check("t4_ack_after", cpu_ack, 1);
    cpu_req = 1'b0; tick();
    model_scroll();
    shadow[5] = 'h77;
    cpu_access(1'b0, 0, 0, r, lat, wen);    check("t4_cell0", r, 'h50);
    cpu_access(1'b0, 4719, 0, r, lat, wen); check("t4_cell4719", r, 'h3F);
    cpu_access(1'b0, 4720, 0, r, lat, wen); check("t4_cell4720", r, 'h20);
    cpu_access(1'b0, 5, 0, r, lat, wen);    check("t4_cell5", r, 'h77);
    vga_sweep(0, CELLS - 1, "t4_vga");

    // 5: clear wins over simultaneous scroll; commands while busy ignored; VGA steals
    engine_run(1'b1, 1'b1, 25, 100, 1'b0, nb, ns, early);
    check("t5_busy_cycles", nb, CELLS + ns);
    flag = 1'b0;
    repeat (5) begin
      tick();
      if (busy) flag = 1'b1;
    end
    check("t5_stays_idle", flag, 0);
    model_clear();
    for (int k = 0; k < 20; k++) begin
      int a;
      a = $urandom_range(CELLS - 1);
      cpu_access(1'b0, a, 0, r, lat, wen);
      check("t5_rd", r, exp_cell(a));
    end

    // 6: reset mid-scroll on a row-periodic screen, then a full scroll
    for (int i = 0; i < CELLS; i++) cpu_write(i, i % COLS);
    cmd_scroll = 1'b1; tick(); cmd_scroll = 1'b0;
    repeat (500) tick();
    check("t6_busy_mid", busy, 1);
    clrn = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_vga_valid", vga_valid, 0);
    check("t6_rst_cpu_ack", cpu_ack, 0);
    check("t6_rst_ram_we", ram_we, 0);
    check("t6_rst_vga_data", vga_data, 0);
    repeat (2) tick();
    clrn = 1'b1;
    tick();
    check("t6_busy_after", busy, 0);
    engine_run(1'b0, 1'b1, 0, -1, 1'b0, nb, ns, early);
    check("t6_busy_cycles", nb, 2 * (CELLS - COLS) + COLS);
    model_scroll();
    vga_sweep(0, CELLS - 1, "t6_vga");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
